// File: rtl/memoria_datos_mips.sv
// Byte-addressable MIPS data memory: LB/LBU/LH/LHU/LW and SB/SH/SW with misalignment detection,
// a 1- or 2-cycle response pipeline, and an independent read-only debug port.
module memoria_datos_mips #(
  parameter int    RAM_DEPTH       = 1024,
  parameter int    NB_ADDR         = 12,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic                         i_wr,
  input  logic [1:0]                   i_size,
  input  logic                         i_unsigned,
  input  logic [NB_ADDR-1:0]           i_addr,
  input  logic [31:0]                  i_data,
  output logic [31:0]                  o_data,
  output logic                         o_valid,
  output logic                         o_error,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_dbg_addr,
  output logic [31:0]                  o_dbg_data
);

  localparam int NB_WADDR  = $clog2(RAM_DEPTH);
  localparam bit HIGH_PERF = (RAM_PERFORMANCE == "HIGH_PERFORMANCE");

  logic [31:0] mem [0:RAM_DEPTH-1] = '{default: 32'h0};

  logic [NB_WADDR-1:0] word_idx;
  logic [1:0]          off;
  logic                req_err;
  logic [3:0]          lane_en;
  logic [31:0]         wr_data;

  assign word_idx = i_addr[NB_ADDR-1:2];
  assign off      = i_addr[1:0];

  always_comb begin
    req_err = 1'b0;
    lane_en = 4'b0000;
    wr_data = i_data;
    case (i_size)
      2'b00: begin
        lane_en = 4'b0001 << off;
        wr_data = {4{i_data[7:0]}};
      end
      2'b01: begin
        req_err = off[0];
        lane_en = 4'b0011 << off;
        wr_data = {2{i_data[15:0]}};
      end
      2'b11: begin
        req_err = |off;
        lane_en = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
    if (req_err) lane_en = 4'b0000;
  end

  // RAM array has no reset; writes are blocked while reset is held.
  always_ff @(posedge i_clk) begin
    if (i_reset && i_valid && i_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  logic        v1, wr1, err1, uns1;
  logic [1:0]  off1, size1;
  logic [31:0] rd_word;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      v1         <= 1'b0;
      wr1        <= 1'b0;
      err1       <= 1'b0;
      uns1       <= 1'b0;
      off1       <= 2'b00;
      size1      <= 2'b00;
      rd_word    <= 32'h0;
      o_dbg_data <= 32'h0;
    end else begin
      v1         <= i_valid;
      wr1        <= i_wr;
      err1       <= req_err;
      uns1       <= i_unsigned;
      off1       <= off;
      size1      <= i_size;
      rd_word    <= mem[word_idx];
      o_dbg_data <= mem[i_dbg_addr];
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] resp_data;
  logic        resp_valid, resp_err;

  always_comb begin
    byte_sel = rd_word[{off1, 3'b000} +: 8];
    half_sel = rd_word[{off1[1], 4'b0000} +: 16];
    case (size1)
      2'b00:   load_ext = {{24{~uns1 & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns1 & half_sel[15]}}, half_sel};
      default: load_ext = rd_word;
    endcase
    resp_valid = v1;
    resp_err   = v1 & err1;
    resp_data  = (v1 && !wr1 && !err1) ? load_ext : 32'h0;
  end

  if (HIGH_PERF) begin : g_hp
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        o_valid <= 1'b0;
        o_error <= 1'b0;
        o_data  <= 32'h0;
      end else begin
        o_valid <= resp_valid;
        o_error <= resp_err;
        o_data  <= resp_data;
      end
    end
  end else begin : g_ll
    assign o_valid = resp_valid;
    assign o_error = resp_err;
    assign o_data  = resp_data;
  end

endmodule

// File: tb/tb_memoria_datos_mips.sv
// Directed bench for memoria_datos_mips: table of single-cycle accesses on a low-latency
// instance, plus hand-written debug, high-performance pipeline and reset sequences.
module tb_memoria_datos_mips;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0, wr = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b11;
  logic [11:0] addr = '0;
  logic [31:0] data = '0;
  logic [9:0]  dbg_addr = '0;

  logic [31:0] ll_data, hp_data, ll_dbg, hp_dbg;
  logic        ll_valid, hp_valid, ll_err, hp_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memoria_datos_mips #(.RAM_DEPTH(1024), .NB_ADDR(12), .RAM_PERFORMANCE("LOW_LATENCY")) dut_ll (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_wr(wr), .i_size(size),
    .i_unsigned(uns), .i_addr(addr), .i_data(data), .o_data(ll_data),
    .o_valid(ll_valid), .o_error(ll_err), .i_dbg_addr(dbg_addr), .o_dbg_data(ll_dbg)
  );

  memoria_datos_mips #(.RAM_DEPTH(1024), .NB_ADDR(12), .RAM_PERFORMANCE("HIGH_PERFORMANCE")) dut_hp (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_wr(wr), .i_size(size),
    .i_unsigned(uns), .i_addr(addr), .i_data(data), .o_data(hp_data),
    .o_valid(hp_valid), .o_error(hp_err), .i_dbg_addr(dbg_addr), .o_dbg_data(hp_dbg)
  );

  typedef struct {
    logic        valid;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] data;
    logic        exp_valid;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] s, input logic u,
                       input logic [11:0] a, input logic [31:0] d);
    valid = v; wr = w; size = s; uns = u; addr = a; data = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b11, 1'b0, 12'h000, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                v  wr size   u  addr     data           ev ee exp_data
    vecs.push_back('{1, 1, 2'b11, 0, 12'h000, 32'hDEADBEEF, 1, 0, 32'h00000000});
    vecs.push_back('{1, 0, 2'b11, 0, 12'h000, 32'h0,        1, 0, 32'hDEADBEEF});
    vecs.push_back('{1, 0, 2'b00, 0, 12'h000, 32'h0,        1, 0, 32'hFFFFFFEF});
    vecs.push_back('{1, 0, 2'b00, 1, 12'h003, 32'h0,        1, 0, 32'h000000DE});
    vecs.push_back('{1, 0, 2'b01, 0, 12'h002, 32'h0,        1, 0, 32'hFFFFDEAD});
    vecs.push_back('{1, 0, 2'b01, 1, 12'h000, 32'h0,        1, 0, 32'h0000BEEF});
    vecs.push_back('{0, 0, 2'b11, 0, 12'h000, 32'h0,        0, 0, 32'h00000000});
    vecs.push_back('{1, 1, 2'b00, 0, 12'h005, 32'h77777712, 1, 0, 32'h00000000});
    vecs.push_back('{1, 1, 2'b01, 0, 12'h006, 32'h99993456, 1, 0, 32'h00000000});
    vecs.push_back('{1, 0, 2'b11, 0, 12'h004, 32'h0,        1, 0, 32'h34561200});
    vecs.push_back('{1, 1, 2'b01, 0, 12'h001, 32'hFFFFFFFF, 1, 1, 32'h00000000});
    vecs.push_back('{1, 0, 2'b11, 0, 12'h002, 32'h0,        1, 1, 32'h00000000});
    vecs.push_back('{1, 0, 2'b10, 0, 12'h000, 32'h0,        1, 1, 32'h00000000});
    vecs.push_back('{1, 1, 2'b10, 0, 12'h008, 32'hFFFFFFFF, 1, 1, 32'h00000000});
    vecs.push_back('{1, 1, 2'b11, 0, 12'h00E, 32'hFFFFFFFF, 1, 1, 32'h00000000});
    vecs.push_back('{1, 0, 2'b11, 0, 12'h000, 32'h0,        1, 0, 32'hDEADBEEF});
    vecs.push_back('{1, 0, 2'b11, 0, 12'h008, 32'h0,        1, 0, 32'h00000000});
    vecs.push_back('{1, 0, 2'b11, 0, 12'h00C, 32'h0,        1, 0, 32'h00000000});
    vecs.push_back('{1, 0, 2'b00, 0, 12'h005, 32'h0,        1, 0, 32'h00000012});
    vecs.push_back('{1, 0, 2'b00, 0, 12'h007, 32'h0,        1, 0, 32'h00000034});
    vecs.push_back('{1, 0, 2'b01, 0, 12'h006, 32'h0,        1, 0, 32'h00003456});
    vecs.push_back('{1, 0, 2'b00, 0, 12'h001, 32'h0,        1, 0, 32'hFFFFFFBE});
    vecs.push_back('{1, 0, 2'b00, 1, 12'h001, 32'h0,        1, 0, 32'h000000BE});
    vecs.push_back('{1, 0, 2'b01, 0, 12'h000, 32'h0,        1, 0, 32'hFFFFBEEF});

    // Reset state
    idle();
    step();
    step();
    chk("reset o_valid", {31'b0, ll_valid}, 32'h0);
    chk("reset o_error", {31'b0, ll_err}, 32'h0);
    chk("reset o_data", ll_data, 32'h0);
    chk("reset o_dbg_data", ll_dbg, 32'h0);
    chk("reset hp o_valid", {31'b0, hp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Table: each vector occupies one cycle, response sampled just after the consuming edge
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].data);
      step();
      chk($sformatf("vec%0d o_valid", i), {31'b0, ll_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d o_error", i), {31'b0, ll_err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d o_data", i), ll_data, vecs[i].exp_data);
    end
    idle();
    step();
    chk("idle o_valid", {31'b0, ll_valid}, 32'h0);

    // Debug port read-first against a same-cycle store
    dbg_addr = 10'd4;
    drive(1'b1, 1'b1, 2'b11, 1'b0, 12'h010, 32'hA5A5A5A5);
    step();
    chk("dbg old value", ll_dbg, 32'h0);
    chk("dbg store o_valid", {31'b0, ll_valid}, 32'h1);
    idle();
    step();
    chk("dbg new value", ll_dbg, 32'hA5A5A5A5);
    chk("dbg hp instance", hp_dbg, 32'hA5A5A5A5);
    dbg_addr = 10'd1;
    step();
    chk("dbg word1", ll_dbg, 32'h34561200);

    // High-performance: back-to-back loads, 2-cycle latency
    drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h000, 32'h0);
    step();
    chk("hp lat1 o_valid", {31'b0, hp_valid}, 32'h0);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h004, 32'h0);
    step();
    chk("hp first o_valid", {31'b0, hp_valid}, 32'h1);
    chk("hp first o_data", hp_data, 32'hDEADBEEF);
    idle();
    step();
    chk("hp second o_valid", {31'b0, hp_valid}, 32'h1);
    chk("hp second o_data", hp_data, 32'h34561200);
    step();
    chk("hp drain o_valid", {31'b0, hp_valid}, 32'h0);
    chk("hp drain o_data", hp_data, 32'h0);

    // Reset mid-pipeline; a store under reset must be ignored
    drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h000, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("midreset ll o_valid", {31'b0, ll_valid}, 32'h0);
    drive(1'b1, 1'b1, 2'b11, 1'b0, 12'h000, 32'hFFFFFFFF);
    step();
    idle();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("postreset%0d hp o_valid", c), {31'b0, hp_valid}, 32'h0);
      chk($sformatf("postreset%0d ll o_valid", c), {31'b0, ll_valid}, 32'h0);
    end
    drive(1'b1, 1'b0, 2'b11, 1'b0, 12'h000, 32'h0);
    step();
    chk("intact ll o_data", ll_data, 32'hDEADBEEF);
    idle();
    step();
    chk("intact hp o_valid", {31'b0, hp_valid}, 32'h1);
    chk("intact hp o_data", hp_data, 32'hDEADBEEF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
